alu_iter_exec: RTL
==================

ALU_ITER_EXEC -- requirements
Module: alu_iter_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits.
REQ-002 SHALL have parameter SHAMT_W, default 5: shift-amount width, equal to log2(WIDTH).
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port ALUControl  input  4  operation code from the ALU decoder, encoded per alu_pkg.
REQ-008 SHALL have port a  input  WIDTH  first operand.
REQ-009 SHALL have port b  input  WIDTH  second operand; b[SHAMT_W-1:0] is the shift amount.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port zero  output  1  result equals 0.
REQ-014 SHALL have port illegal  output  1  the captured ALUControl was not a defined code.

Function
REQ-015 SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-016 SHALL drive in_ready=1 only in IDLE; a request is accepted when in_valid and in_ready are both 1, and a, b and ALUControl are registered at that edge.
REQ-017 SHALL, for ADD, SUB, AND, OR, XOR, SLT (signed) and SLTU (unsigned) requests, compute the result at the accept edge and move IDLE->DONE, so out_valid rises 1 cycle after acceptance.
REQ-018 SHALL wrap ADD and SUB modulo 2^WIDTH, with no overflow flag; SLT and SLTU SHALL return 0 or 1, zero-extended.
REQ-019 SHALL, for SLL, SRL and SRA requests with shamt>0, move IDLE->SHIFT and shift the working register by exactly 1 bit per cycle, decrementing a shamt counter until it reaches 0, then move to DONE; out_valid SHALL rise shamt+1 cycles after acceptance.
REQ-020 SHALL treat a shift with shamt=0 as a 1-cycle operation (IDLE->DONE) whose result is a unchanged.
REQ-021 SHALL fill SRA with the sign bit of a, and SRL and SLL with zeros.
REQ-022 SHALL, for an undefined ALUControl, go IDLE->DONE in 1 cycle with result=0, zero=1 and illegal=1.
REQ-023 SHALL hold result, zero, illegal and out_valid stable in DONE until out_ready=1; the handshake edge SHALL move DONE->IDLE.
REQ-024 SHALL ignore in_valid while in SHIFT or DONE; operands do not need to be held by the requester after acceptance.
REQ-025 SHALL give a sustained throughput of at most 1 operation per 2 cycles, since in_ready stays low in the cycle out_valid&out_ready fires.

Reset
REQ-026 SHALL, while reset=0, force state=IDLE, in_ready=1, out_valid=0, result=0, zero=0, illegal=0 and shamt counter=0, asynchronously.
REQ-027 SHALL abandon any in-progress shift or unconsumed result when reset is asserted mid-operation; no result is presented after reset is released.
REQ-028 SHALL be able to accept a request on the first rising edge after reset is released.

Structure
REQ-029 SHALL take the ALUControl codes from shared package alu_pkg: ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SLT=0101, SLTU=0110, XOR=0111, SRL=1000, SRA=1001; all other codes are illegal.
REQ-030 SHALL also take the state enumeration from alu_pkg, so that the decoder and this block share one definition.
REQ-031 SHALL place the per-cycle 1-bit shift step in sub-module alu_shift_step (inputs: value, dir, arith; output: shifted value); all other logic is flat.

Verification
REQ-032 SHALL cover: ADD a=0xFFFFFFFF, b=1 -> result=0, zero=1, out_valid exactly 1 cycle after accept.
REQ-033 SHALL cover: SRA a=0x80000000, b=4 -> result=0xF8000000, out_valid 5 cycles after accept, in_ready=0 throughout.
REQ-034 SHALL cover: SLT a=0xFFFFFFFF, b=1 -> result=1; then SLTU on the same operands -> result=0.
REQ-035 SHALL cover: SLL a=1, b=31, with out_ready held low 3 extra cycles -> result=0x80000000 held stable; IDLE entered on the handshake edge.
REQ-036 SHALL cover: reset pulsed low during SRL with b=20, mid-shift -> out_valid=0 and in_ready=1 immediately; the next request completes correctly.
REQ-037 SHALL cover: ALUControl=1111 -> illegal=1, result=0, zero=1 after 1 cycle; in_valid=1 during DONE is not accepted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: the ALUControl opcode encoding used by the decoder
// and the execution unit, and the iterative executor's state enumeration.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_iter_exec_if.sv
// Request/response bundle of the iterative ALU.
//   master : requester side (drives in_valid/ALUControl/a/b, out_ready)
//   slave  : execution unit side (drives in_ready, out_valid, result, zero, illegal)
interface alu_iter_exec_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, ALUControl, a, b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, ALUControl, a, b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_shift_step.sv
// One-bit shift step of the iterative shifter.
//   value   : current working value
//   dir     : 0 = shift left, 1 = shift right
//   arith   : on right shifts, fill with value's MSB instead of 0
//   shifted : value shifted by exactly one position
module alu_shift_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             dir,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    if (dir) begin
      shifted = {arith & value[WIDTH-1], value[WIDTH-1:1]};
    end else begin
      shifted = {value[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Iterative ALU execution unit. Logic/arithmetic/compare ops finish in one
// cycle; shifts by a non-zero amount step one bit per cycle in SHIFT.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   ALUControl, a, b    : opcode (alu_pkg encoding) and operands, b[SHAMT_W-1:0] = shamt
//   out_valid/out_ready : response handshake
//   result, zero        : result and result==0 flag
//   illegal             : captured opcode was undefined
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_e         r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_illegal;
  logic [SHAMT_W-1:0] r_shamt;
  logic               r_dir;
  logic               r_arith;

  logic [WIDTH-1:0]   w_alu_res;
  logic               w_illegal;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_shifted;

  always_comb begin
    w_alu_res  = '0;
    w_illegal  = 1'b0;
    w_shamt    = b[SHAMT_W-1:0];
    w_is_shift = is_shift_op(ALUControl);
    case (ALUControl)
      ALU_ADD:  w_alu_res = a + b;
      ALU_SUB:  w_alu_res = a - b;
      ALU_AND:  w_alu_res = a & b;
      ALU_OR:   w_alu_res = a | b;
      ALU_XOR:  w_alu_res = a ^ b;
      ALU_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      // Only reaches DONE directly when shamt==0, where the result is a unchanged.
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = a;
      default:  w_illegal = 1'b1;
    endcase
  end

  alu_shift_step #(.WIDTH(WIDTH)) u_shift_step (
    .value   (r_result),
    .dir     (r_dir),
    .arith   (r_arith),
    .shifted (w_shifted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_shamt     <= '0;
      r_dir       <= 1'b0;
      r_arith     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_dir      <= (ALUControl != ALU_SLL);
            r_arith    <= (ALUControl == ALU_SRA);
            if (w_is_shift && (w_shamt != '0)) begin
              // r_result doubles as the shifter's working register.
              r_state   <= ST_SHIFT;
              r_result  <= a;
              r_shamt   <= w_shamt;
              r_zero    <= 1'b0;
              r_illegal <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_illegal   <= w_illegal;
            end
          end
        end
        ST_SHIFT: begin
          r_result <= w_shifted;
          r_shamt  <= r_shamt - SHAMT_W'(1);
          if (r_shamt == SHAMT_W'(1)) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_zero      <= (w_shifted == '0);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule
